// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ASB_REGB  = 2'b00;
   localparam logic [1:0] ASB_FOUR  = 2'b01;
   localparam logic [1:0] ASB_IMM   = 2'b10;
   localparam logic [1:0] ASB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state_o;

   modport master (
      input  op, funct, zero,
      output iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, state_o
   );

   modport slave (
      output op, funct, zero,
      input  iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, state_o
   );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALU operation class and R-type funct field to the 3-bit ALU function.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            // Unknown funct falls back to ADD; the instruction still completes
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath: fetch, decode,
// execute, memory and writeback sequencing with per-state datapath controls.
module mc_controller
   import mc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   logic       w_iord;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_regdst;
   logic       w_memtoreg;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_pcsrc;
   logic [1:0] w_aluop;
   logic [1:0] w_aluop_g;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_illegal;
   logic [2:0] w_alucontrol;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Next-state and per-state control decode
   always_comb begin
      w_next     = S_FETCH;
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = ASB_REGB;
      w_pcsrc    = PCSRC_ALU;
      w_aluop    = ALUOP_ADD;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_illegal  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_alusrcb = ASB_FOUR;
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            w_alusrcb = ASB_IMMSH;
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = ASB_IMM;
            w_next    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_iord = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
         end
         S_MEMWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTE: begin
            w_alusrca = 1'b1;
            w_aluop   = ALUOP_FUNCT;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
         end
         S_BRANCH: begin
            w_alusrca = 1'b1;
            w_aluop   = ALUOP_SUB;
            w_pcsrc   = PCSRC_ALUOUT;
            w_branch  = 1'b1;
         end
         S_ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = ASB_IMM;
            w_next    = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
         end
         S_JUMP: begin
            w_pcsrc   = PCSRC_JUMP;
            w_pcwrite = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign w_aluop_g = reset ? ALUOP_ADD : w_aluop;

   alu_decoder u_alu_decoder (
      .aluop      (w_aluop_g),
      .funct      (bus.funct),
      .alucontrol (w_alucontrol)
   );

   // Reset masks every output in the same cycle so an aborted instruction never writes
   assign bus.iord       = ~reset & w_iord;
   assign bus.memwrite   = ~reset & w_memwrite;
   assign bus.irwrite    = ~reset & w_irwrite;
   assign bus.regwrite   = ~reset & w_regwrite;
   assign bus.regdst     = ~reset & w_regdst;
   assign bus.memtoreg   = ~reset & w_memtoreg;
   assign bus.alusrca    = ~reset & w_alusrca;
   assign bus.alusrcb    = reset ? 2'b00 : w_alusrcb;
   assign bus.pcsrc      = reset ? 2'b00 : w_pcsrc;
   assign bus.pcen       = ~reset & (w_pcwrite | (w_branch & bus.zero));
   assign bus.alucontrol = w_alucontrol;
   assign bus.illegal    = ~reset & w_illegal;
   assign bus.state_o    = reset ? 4'd0 : 4'(r_state);

endmodule
